// File: rtl/nms_stream_pipe_if.sv
// nms_stream_pipe_if
//   Stream bundle for the non-maximum suppression stage.
//   Input side : in_valid / in_ready handshake, 3x3 window in_mag, centre in_dir.
//   Output side: out_valid / out_ready handshake, thinned out_mag, aligned out_dir.
//   Modports:
//     master - the producer/consumer environment around the stage
//     slave  - the stage itself
interface nms_stream_pipe_if #(
  parameter int MAG_W = 11,
  parameter int DIR_W = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [9*MAG_W-1:0] in_mag;
  logic [DIR_W-1:0]   in_dir;
  logic               out_valid;
  logic               out_ready;
  logic [MAG_W-1:0]   out_mag;
  logic [DIR_W-1:0]   out_dir;

  modport master (
    output in_valid, in_mag, in_dir, out_ready,
    input  in_ready, out_valid, out_mag, out_dir
  );

  modport slave (
    input  in_valid, in_mag, in_dir, out_ready,
    output in_ready, out_valid, out_mag, out_dir
  );
endinterface

// File: rtl/nms_stream_pipe.sv
// nms_stream_pipe
//   Streaming non-maximum suppression for the edge detector. Each beat carries a
//   3x3 gradient-magnitude window and the direction of the centre pixel; the
//   stage outputs the centre magnitude if it is a local maximum along that
//   direction, otherwise 0, with the direction kept in the same beat.
//   Three registered stages (capture, decide, output) with full valid/ready
//   backpressure; bubbles collapse.
// Ports
//   clk         clock, rising edge
//   rstN        synchronous active-low reset
//   s           stream bundle (nms_stream_pipe_if.slave)
//   clear_cnt   synchronous clear of supp_count (wins over an increment)
//   supp_count  saturating count of suppressed beats
//   thr_lo/thr_hi/edge_cls  only with NMS_HYST_EN: weak/strong classification
// Configuration macro: NMS_HYST_EN
module nms_stream_pipe #(
  parameter int MAG_W    = 11,
  parameter int DIR_W    = 2,
  parameter int CNT_W    = 20,
  parameter int TIE_MODE = 0
) (
  input  logic             clk,
  input  logic             rstN,
  nms_stream_pipe_if.slave s,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] supp_count
`ifdef NMS_HYST_EN
  ,
  input  logic [MAG_W-1:0] thr_lo,
  input  logic [MAG_W-1:0] thr_hi,
  output logic [1:0]       edge_cls
`endif
);

  logic               s1Valid_q;
  logic [9*MAG_W-1:0] s1Mag_q;
  logic [DIR_W-1:0]   s1Dir_q;

  logic               s2Valid_q;
  logic [MAG_W-1:0]   s2Mag_q;
  logic [DIR_W-1:0]   s2Dir_q;
  logic               s2Supp_q;

  logic               s3Valid_q;
  logic [MAG_W-1:0]   s3Mag_q;
  logic [DIR_W-1:0]   s3Dir_q;

  logic [CNT_W-1:0]   suppCnt_q;
  logic [CNT_W-1:0]   suppCnt_d;

  logic [MAG_W-1:0]   s2Mag_d;
  logic               s2Supp_d;

  logic [MAG_W-1:0]   pix [9];
  logic [MAG_W-1:0]   nbrA;
  logic [MAG_W-1:0]   nbrB;
  logic               keepCentre;

  logic               adv1;
  logic               adv2;
  logic               adv3;

`ifdef NMS_HYST_EN
  logic [1:0]         s2Cls_d;
  logic [1:0]         s2Cls_q;
  logic [1:0]         s3Cls_q;
`endif

  // A stage moves when it is empty or the stage after it moves.
  assign adv3 = !s3Valid_q || s.out_ready;
  assign adv2 = !s2Valid_q || adv3;
  assign adv1 = !s1Valid_q || adv2;

  assign s.in_ready  = adv1;
  assign s.out_valid = s3Valid_q;
  assign s.out_mag   = s3Mag_q;
  assign s.out_dir   = s3Dir_q;
  assign supp_count  = suppCnt_q;

  // Neighbour pair chosen by the low two direction bits only; wider direction
  // codes are carried through untouched.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      pix[i] = s1Mag_q[i*MAG_W +: MAG_W];
    end
    nbrA = pix[3];
    nbrB = pix[5];
    case (s1Dir_q[1:0])
      2'd1: begin nbrA = pix[1]; nbrB = pix[7]; end
      2'd2: begin nbrA = pix[2]; nbrB = pix[6]; end
      2'd3: begin nbrA = pix[0]; nbrB = pix[8]; end
      default: ;
    endcase
    if (TIE_MODE != 0) begin
      keepCentre = (pix[4] > nbrA) && (pix[4] >= nbrB);
    end else begin
      keepCentre = (pix[4] >= nbrA) && (pix[4] >= nbrB);
    end
    // A zero centre already outputs 0, so it never counts as suppressed.
    s2Supp_d = (pix[4] != '0) && !keepCentre;
    s2Mag_d  = s2Supp_d ? '0 : pix[4];
  end

`ifdef NMS_HYST_EN
  always_comb begin
    s2Cls_d = 2'd0;
    if (!s2Supp_d) begin
      if (s2Mag_d >= thr_hi) begin
        s2Cls_d = 2'd2;
      end else if (s2Mag_d >= thr_lo) begin
        s2Cls_d = 2'd1;
      end
    end
  end
  assign edge_cls = s3Cls_q;
`endif

  // Count a suppressed beat as it enters the output register.
  always_comb begin
    suppCnt_d = suppCnt_q;
    if (clear_cnt) begin
      suppCnt_d = '0;
    end else if (adv3 && s2Valid_q && s2Supp_q && !(&suppCnt_q)) begin
      suppCnt_d = suppCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      s1Valid_q <= 1'b0;
      s1Mag_q   <= '0;
      s1Dir_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Mag_q   <= '0;
      s2Dir_q   <= '0;
      s2Supp_q  <= 1'b0;
      s3Valid_q <= 1'b0;
      s3Mag_q   <= '0;
      s3Dir_q   <= '0;
      suppCnt_q <= '0;
`ifdef NMS_HYST_EN
      s2Cls_q   <= 2'd0;
      s3Cls_q   <= 2'd0;
`endif
    end else begin
      suppCnt_q <= suppCnt_d;
      if (adv1) begin
        s1Valid_q <= s.in_valid;
        if (s.in_valid) begin
          s1Mag_q <= s.in_mag;
          s1Dir_q <= s.in_dir;
        end
      end
      if (adv2) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Mag_q  <= s2Mag_d;
          s2Dir_q  <= s1Dir_q;
          s2Supp_q <= s2Supp_d;
`ifdef NMS_HYST_EN
          s2Cls_q  <= s2Cls_d;
`endif
        end
      end
      // Output data only changes on an advance, so it holds during a stall.
      if (adv3) begin
        s3Valid_q <= s2Valid_q;
        if (s2Valid_q) begin
          s3Mag_q <= s2Mag_q;
          s3Dir_q <= s2Dir_q;
`ifdef NMS_HYST_EN
          s3Cls_q <= s2Cls_q;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_nms_stream_pipe.sv
// tb_nms_stream_pipe
//   Drives two instances of nms_stream_pipe with identical beats:
//     dutA: DIR_W=2, CNT_W=3 (small counter to reach saturation), TIE_MODE=0
//     dutB: DIR_W=3, CNT_W=20, TIE_MODE=1
//   Expected outputs are queued at accept time and popped by a monitor
//   whenever an output beat is presented.
`timescale 1ns/1ps
module tb_nms_stream_pipe;
  localparam int MAG_W  = 11;
  localparam int DIR_WA = 2;
  localparam int DIR_WB = 3;
  localparam int CNT_WA = 3;
  localparam int CNT_WB = 20;
  localparam int SAT_A  = (1 << CNT_WA) - 1;
  localparam int SAT_B  = (1 << CNT_WB) - 1;

  typedef struct {
    int unsigned mag;
    int unsigned dir;
    int unsigned cls;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic clearCnt = 1'b0;
  logic [CNT_WA-1:0] cntA;
  logic [CNT_WB-1:0] cntB;
  always #5 clk = ~clk;

  nms_stream_pipe_if #(.MAG_W(MAG_W), .DIR_W(DIR_WA)) ifA ();
  nms_stream_pipe_if #(.MAG_W(MAG_W), .DIR_W(DIR_WB)) ifB ();

`ifdef NMS_HYST_EN
  logic [MAG_W-1:0] thrLo = 11'd4;
  logic [MAG_W-1:0] thrHi = 11'd8;
  logic [1:0] clsA;
  logic [1:0] clsB;
`endif

  nms_stream_pipe #(.MAG_W(MAG_W), .DIR_W(DIR_WA), .CNT_W(CNT_WA), .TIE_MODE(0)) dutA (
    .clk(clk), .rstN(rstN), .s(ifA), .clear_cnt(clearCnt), .supp_count(cntA)
`ifdef NMS_HYST_EN
    , .thr_lo(thrLo), .thr_hi(thrHi), .edge_cls(clsA)
`endif
  );

  nms_stream_pipe #(.MAG_W(MAG_W), .DIR_W(DIR_WB), .CNT_W(CNT_WB), .TIE_MODE(1)) dutB (
    .clk(clk), .rstN(rstN), .s(ifB), .clear_cnt(clearCnt), .supp_count(cntB)
`ifdef NMS_HYST_EN
    , .thr_lo(thrLo), .thr_hi(thrHi), .edge_cls(clsB)
`endif
  );

  int total = 0;
  int bad = 0;
  bit monOn = 0;
  bit rdyRandom = 0;
  exp_t qA[$];
  exp_t qB[$];
  int modelCntA = 0;
  int modelCntB = 0;
  int pairA[4] = '{3, 1, 2, 0};
  int pairB[4] = '{5, 7, 6, 8};

  // Reference: centre survives if it is a local maximum along the direction.
  function automatic bit refSupp(input int unsigned w[9], input int unsigned d, input int tie);
    int unsigned c, a, b;
    c = w[4];
    a = w[pairA[d % 4]];
    b = w[pairB[d % 4]];
    if (c == 0) return 1'b0;
    if (tie != 0) return !((c > a) && (c >= b));
    return !((c >= a) && (c >= b));
  endfunction

  function automatic int unsigned refCls(input int unsigned m, input bit supp);
    int unsigned lo, hi;
    lo = 4;
    hi = 8;
    if (supp) return 0;
    if (m >= hi) return 2;
    if (m >= lo) return 1;
    return 0;
  endfunction

  task automatic checkEq(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setInputs(input bit v, input logic [9*MAG_W-1:0] flat, input int unsigned d);
    logic [31:0] dv;
    dv = d;
    ifA.in_valid = v;
    ifB.in_valid = v;
    ifA.in_mag   = flat;
    ifB.in_mag   = flat;
    ifA.in_dir   = dv[DIR_WA-1:0];
    ifB.in_dir   = dv[DIR_WB-1:0];
  endtask

  task automatic setReady(input bit r);
    ifA.out_ready = r;
    ifB.out_ready = r;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic applyStimulus(input int unsigned w[9], input int unsigned d);
    logic [9*MAG_W-1:0] flat;
    logic [31:0] tmp;
    bit acc;
    int waited;
    bit sA, sB;
    exp_t eA, eB;
    for (int i = 0; i < 9; i++) begin
      tmp = w[i];
      flat[i*MAG_W +: MAG_W] = tmp[MAG_W-1:0];
    end
    setInputs(1'b1, flat, d);
    acc = 0;
    waited = 0;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = ifA.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: beat not accepted within 100 cycles");
    end else begin
      sA = refSupp(w, d % 4, 0);
      sB = refSupp(w, d % 4, 1);
      eA.mag = sA ? 0 : w[4];
      eA.dir = d % (1 << DIR_WA);
      eA.cls = refCls(eA.mag, sA);
      eB.mag = sB ? 0 : w[4];
      eB.dir = d % (1 << DIR_WB);
      eB.cls = refCls(eB.mag, sB);
      qA.push_back(eA);
      qB.push_back(eB);
      if (sA && modelCntA < SAT_A) modelCntA++;
      if (sB && modelCntB < SAT_B) modelCntB++;
    end
  endtask

  task automatic idle(input int n);
    setInputs(1'b0, '0, 0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input int which, input bit v, input bit rdy,
                             input int unsigned m, input int unsigned d, input int unsigned c);
    exp_t e;
    string nm;
    nm = (which == 0) ? "A" : "B";
    if (!v) return;
    if ((which == 0 && qA.size() == 0) || (which == 1 && qB.size() == 0)) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_out_%s: out_valid with no pending beat, mag=%0d", nm, m);
      return;
    end
    e = (which == 0) ? qA[0] : qB[0];
    total++;
    if (m != e.mag || d != e.dir) begin
      bad++;
      $display("[TB] FAIL out_%s: got mag=%0d dir=%0d expected mag=%0d dir=%0d at %0t",
               nm, m, d, e.mag, e.dir, $time);
    end
`ifdef NMS_HYST_EN
    checkEq({"edge_cls_", nm}, c, e.cls);
`else
    if (c != 0) checkEq({"cls_unused_", nm}, c, 0);
`endif
    if (rdy) begin
      if (which == 0) void'(qA.pop_front());
      else void'(qB.pop_front());
    end
  endtask

  // Monitor: compares every presented output beat against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (monOn && rstN) begin
`ifdef NMS_HYST_EN
        checkOutput(0, ifA.out_valid, ifA.out_ready, ifA.out_mag, ifA.out_dir, clsA);
        checkOutput(1, ifB.out_valid, ifB.out_ready, ifB.out_mag, ifB.out_dir, clsB);
`else
        checkOutput(0, ifA.out_valid, ifA.out_ready, ifA.out_mag, ifA.out_dir, 0);
        checkOutput(1, ifB.out_valid, ifB.out_ready, ifB.out_mag, ifB.out_dir, 0);
`endif
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdyRandom) setReady($urandom_range(0, 3) != 0);
    end
  end

  task automatic drain();
    int n;
    setInputs(1'b0, '0, 0);
    n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (qA.size() != 0 || qB.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: pending A=%0d B=%0d", qA.size(), qB.size());
      qA.delete();
      qB.delete();
    end
    idle(2);
  endtask

  task automatic checkCounts(input string tag);
    @(negedge clk);
    checkEq({"supp_count_A_", tag}, cntA, modelCntA);
    checkEq({"supp_count_B_", tag}, cntB, modelCntB);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    checkEq({"rst_out_valid_", tag}, ifA.out_valid, 0);
    checkEq({"rst_in_ready_", tag}, ifA.in_ready, 1);
    checkEq({"rst_out_mag_", tag}, ifA.out_mag, 0);
    checkEq({"rst_out_dir_", tag}, ifA.out_dir, 0);
    checkEq({"rst_count_A_", tag}, cntA, 0);
    checkEq({"rst_out_valid_B_", tag}, ifB.out_valid, 0);
    checkEq({"rst_count_B_", tag}, cntB, 0);
`ifdef NMS_HYST_EN
    checkEq({"rst_edge_cls_", tag}, clsA, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic randWindow(output int unsigned w[9]);
    for (int i = 0; i < 9; i++) begin
      if ($urandom_range(0, 3) == 0) w[i] = $urandom_range(0, (1 << MAG_W) - 1);
      else w[i] = $urandom_range(0, 9);
    end
  endtask

  initial begin
    int unsigned w[9];
    setInputs(1'b0, '0, 0);
    setReady(1'b1);
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    checkResetState("initial");
    monOn = 1;

    // Directed beats: kept horizontal, suppressed vertical, 135-degree tie.
    w = '{0, 0, 0, 5, 9, 7, 0, 0, 0};
    applyStimulus(w, 0);
    w = '{0, 12, 0, 0, 9, 0, 0, 3, 0};
    applyStimulus(w, 1);
    w = '{6, 0, 0, 0, 6, 0, 0, 0, 6};
    applyStimulus(w, 3);
    w = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(w, 2);
    w = '{1, 2, 3, 4, 1025, 1024, 7, 8, 9};
    applyStimulus(w, 4);
    drain();
    checkCounts("directed");

`ifdef NMS_HYST_EN
    w = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
    applyStimulus(w, 0);
    w[4] = 5;
    applyStimulus(w, 1);
    w[4] = 8;
    applyStimulus(w, 2);
    drain();
`endif

    // Stall: three beats fill the pipe, downstream held off for four cycles.
    setReady(1'b0);
    for (int k = 0; k < 3; k++) begin
      randWindow(w);
      applyStimulus(w, k);
    end
    setInputs(1'b0, '0, 0);
    repeat (4) begin
      @(negedge clk);
      checkEq("stall_in_ready_A", ifA.in_ready, 0);
      checkEq("stall_in_ready_B", ifB.in_ready, 0);
      @(posedge clk);
      #1;
    end
    setReady(1'b1);
    for (int k = 0; k < 3; k++) begin
      randWindow(w);
      applyStimulus(w, k + 4);
    end
    drain();
    checkCounts("stall");

    // Random stream with random backpressure and input gaps.
    rdyRandom = 1;
    for (int k = 0; k < 300; k++) begin
      randWindow(w);
      applyStimulus(w, $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain();
    checkCounts("random");

    // Saturation and clear-over-increment.
    clearCnt = 1'b1;
    idle(1);
    clearCnt = 1'b0;
    modelCntA = 0;
    modelCntB = 0;
    checkCounts("cleared");
    rdyRandom = 0;
    setReady(1'b1);
    w = '{0, 0, 0, 9, 5, 0, 0, 0, 0};
    for (int k = 0; k < 9; k++) applyStimulus(w, 0);
    drain();
    checkCounts("saturate");
    applyStimulus(w, 0);
    setInputs(1'b0, '0, 0);
    @(posedge clk);
    #1;
    clearCnt = 1'b1;
    @(posedge clk);
    #1;
    clearCnt = 1'b0;
    modelCntA = 0;
    modelCntB = 0;
    drain();
    checkCounts("clear_wins");

    // Reset in the middle of a stalled stream drops everything in flight.
    rdyRandom = 1;
    for (int k = 0; k < 10; k++) begin
      randWindow(w);
      applyStimulus(w, $urandom_range(0, 7));
    end
    rdyRandom = 0;
    setReady(1'b0);
    setInputs(1'b0, '0, 0);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    qA.delete();
    qB.delete();
    modelCntA = 0;
    modelCntB = 0;
    checkResetState("midstream");
    rdyRandom = 1;
    for (int k = 0; k < 20; k++) begin
      randWindow(w);
      applyStimulus(w, $urandom_range(0, 7));
    end
    drain();
    checkCounts("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end
endmodule
